multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_if.sv | 34 +++
 rtl/multicycle_ctrl.sv | 178 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and its datapath
// (IFU, register file, ALU, memory); the controller uses the master modport.
interface multicycle_ctrl_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
    logic [3:0] state_dbg;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal, state_dbg
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal, state_dbg
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style main control FSM (R-type, lw, sw, beq, j, optional addi).
// Define MULTICYCLE_ADDI_EN to decode addi (001000); otherwise it is treated as illegal.
module multicycle_ctrl (
    input  logic                      clk,
    input  logic                      rst,
    multicycle_ctrl_if.master         bus
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EX   = 4'd11,
        S_ADDI_WB   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    state_t     state_reg;
    state_t     state_next;

    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Outputs are a function of the current state only, plus mem_ready/zero
    // gating and the DECODE-cycle illegal flag, so reset clears them at once.
    always_comb begin
        state_next = S_FETCH;
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_source  = 2'b00;
        illegal    = 1'b0;

        case (state_reg)
            S_IDLE: begin
                state_next = S_FETCH;
            end
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'b01;
                ir_write   = bus.mem_ready;
                pc_en      = bus.mem_ready;
                state_next = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (bus.opcode)
                    OP_RTYPE:     state_next = S_EXECUTE;
                    OP_LW, OP_SW: state_next = S_MEM_ADDR;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
`ifdef MULTICYCLE_ADDI_EN
                    OP_ADDI:      state_next = S_ADDI_EX;
`endif
                    default: begin
                        illegal    = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_read   = 1'b1;
                iord       = 1'b1;
                state_next = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_next = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                state_next = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
            end
            S_EXECUTE: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b10;
                state_next = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_source  = 2'b01;
                pc_en      = bus.zero;
                state_next = S_FETCH;
            end
            S_JUMP: begin
                pc_source  = 2'b10;
                pc_en      = 1'b1;
                state_next = S_FETCH;
            end
`ifdef MULTICYCLE_ADDI_EN
            S_ADDI_EX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
`endif
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    assign bus.pc_en      = pc_en;
    assign bus.iord       = iord;
    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.ir_write   = ir_write;
    assign bus.reg_dst    = reg_dst;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.reg_write  = reg_write;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.alu_op     = alu_op;
    assign bus.pc_source  = pc_source;
    assign bus.illegal    = illegal;
    assign bus.state_dbg  = state_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed scoreboard bench for multicycle_ctrl: each stimulus cycle queues the
// expected state and control word, a negedge monitor pops and compares.
module tb_multicycle_ctrl;

    logic clk;
    logic rst;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word layout:
    // [15]pc_en [14]iord [13]mem_read [12]mem_write [11]ir_write [10]reg_dst
    // [9]mem_to_reg [8]reg_write [7]alu_src_a [6:5]alu_src_b [4:3]alu_op
    // [2:1]pc_source [0]illegal
    logic [15:0] ctrl_word;
    assign ctrl_word = {bus.pc_en, bus.iord, bus.mem_read, bus.mem_write, bus.ir_write,
                        bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a,
                        bus.alu_src_b, bus.alu_op, bus.pc_source, bus.illegal};

    localparam logic [15:0] V_ZERO     = 16'h0000;
    localparam logic [15:0] V_FETCH    = 16'hA820;
    localparam logic [15:0] V_FETCH_W  = 16'h2020;
    localparam logic [15:0] V_DECODE   = 16'h0060;
    localparam logic [15:0] V_DEC_ILL  = 16'h0061;
    localparam logic [15:0] V_MEM_ADDR = 16'h00C0;
    localparam logic [15:0] V_MEM_RD   = 16'h6000;
    localparam logic [15:0] V_MEM_WB   = 16'h0300;
    localparam logic [15:0] V_MEM_WR   = 16'h5000;
    localparam logic [15:0] V_EXECUTE  = 16'h0090;
    localparam logic [15:0] V_ALU_WB   = 16'h0500;
    localparam logic [15:0] V_BR_TAKEN = 16'h808A;
    localparam logic [15:0] V_BR_NOT   = 16'h008A;
    localparam logic [15:0] V_JUMP     = 16'h8004;
`ifdef MULTICYCLE_ADDI_EN
    localparam logic [15:0] V_ADDI_EX  = 16'h00C0;
    localparam logic [15:0] V_ADDI_WB  = 16'h0100;
`endif

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    typedef struct {
        logic [3:0]  st;
        logic [15:0] vec;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic compare(input exp_t e);
        n_vec++;
        if (bus.state_dbg !== e.st || ctrl_word !== e.vec) begin
            n_fail++;
            $display("FAIL %s: got state_dbg=%0d ctrl=%h, expected state_dbg=%0d ctrl=%h",
                     e.name, bus.state_dbg, ctrl_word, e.st, e.vec);
        end else begin
            $display("ok   %s: state_dbg=%0d ctrl=%h", e.name, bus.state_dbg, ctrl_word);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            compare(sb_q.pop_front());
        end
    end

    // One clock cycle: drive inputs just after the edge and queue what the DUT
    // must show for the remainder of that cycle.
    task automatic cyc(input logic r, input logic [5:0] op, input logic z, input logic mr,
                       input logic [3:0] st, input logic [15:0] v, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst           = r;
        bus.opcode    = op;
        bus.zero      = z;
        bus.mem_ready = mr;
        e.st   = st;
        e.vec  = v;
        e.name = nm;
        sb_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst           = 1'b1;
        bus.opcode    = OP_R;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;

        cyc(1, OP_R, 0, 1, 4'd0, V_ZERO, "reset hold");
        cyc(1, OP_R, 0, 1, 4'd0, V_ZERO, "reset hold 2");
        cyc(0, OP_R, 0, 1, 4'd0, V_ZERO, "idle after release");

        // R-type; opcode garbage after DECODE must not matter
        cyc(0, OP_R,   0, 1, 4'd1, V_FETCH,   "R fetch");
        cyc(0, OP_R,   0, 1, 4'd2, V_DECODE,  "R decode");
        cyc(0, OP_BAD, 0, 1, 4'd7, V_EXECUTE, "R execute");
        cyc(0, OP_BAD, 0, 1, 4'd8, V_ALU_WB,  "R alu_wb");

        // lw with three wait cycles in MEM_READ; garbage opcode during FETCH
        cyc(0, OP_BAD, 0, 1, 4'd1, V_FETCH,    "lw fetch");
        cyc(0, OP_LW,  0, 1, 4'd2, V_DECODE,   "lw decode");
        cyc(0, OP_LW,  0, 1, 4'd3, V_MEM_ADDR, "lw mem_addr");
        cyc(0, OP_LW,  0, 0, 4'd4, V_MEM_RD,   "lw mem_read wait1");
        cyc(0, OP_LW,  0, 0, 4'd4, V_MEM_RD,   "lw mem_read wait2");
        cyc(0, OP_LW,  0, 0, 4'd4, V_MEM_RD,   "lw mem_read wait3");
        cyc(0, OP_LW,  0, 1, 4'd4, V_MEM_RD,   "lw mem_read done");
        cyc(0, OP_LW,  0, 1, 4'd5, V_MEM_WB,   "lw mem_wb");

        // sw with one fetch wait and one write wait
        cyc(0, OP_SW, 0, 0, 4'd1, V_FETCH_W,  "sw fetch wait");
        cyc(0, OP_SW, 0, 1, 4'd1, V_FETCH,    "sw fetch");
        cyc(0, OP_SW, 0, 1, 4'd2, V_DECODE,   "sw decode");
        cyc(0, OP_SW, 0, 1, 4'd3, V_MEM_ADDR, "sw mem_addr");
        cyc(0, OP_SW, 0, 0, 4'd6, V_MEM_WR,   "sw mem_write wait");
        cyc(0, OP_SW, 0, 1, 4'd6, V_MEM_WR,   "sw mem_write done");

        // beq taken, then not taken
        cyc(0, OP_BEQ, 1, 1, 4'd1, V_FETCH,    "beq1 fetch");
        cyc(0, OP_BEQ, 1, 1, 4'd2, V_DECODE,   "beq1 decode");
        cyc(0, OP_BEQ, 1, 1, 4'd9, V_BR_TAKEN, "beq zero=1 branch");
        cyc(0, OP_BEQ, 0, 1, 4'd1, V_FETCH,    "beq0 fetch");
        cyc(0, OP_BEQ, 0, 1, 4'd2, V_DECODE,   "beq0 decode");
        cyc(0, OP_BEQ, 0, 1, 4'd9, V_BR_NOT,   "beq zero=0 branch");

        // jump
        cyc(0, OP_J, 0, 1, 4'd1,  V_FETCH,  "j fetch");
        cyc(0, OP_J, 0, 1, 4'd2,  V_DECODE, "j decode");
        cyc(0, OP_J, 0, 1, 4'd10, V_JUMP,   "j jump");

        // unsupported opcode
        cyc(0, OP_BAD, 0, 1, 4'd1, V_FETCH,   "bad fetch");
        cyc(0, OP_BAD, 0, 1, 4'd2, V_DEC_ILL, "bad decode illegal");

        // addi
        cyc(0, OP_ADDI, 0, 1, 4'd1, V_FETCH, "addi fetch");
`ifdef MULTICYCLE_ADDI_EN
        cyc(0, OP_ADDI, 0, 1, 4'd2,  V_DECODE,  "addi decode");
        cyc(0, OP_ADDI, 0, 1, 4'd11, V_ADDI_EX, "addi ex");
        cyc(0, OP_ADDI, 0, 1, 4'd12, V_ADDI_WB, "addi wb");
`else
        cyc(0, OP_ADDI, 0, 1, 4'd2,  V_DEC_ILL, "addi decode illegal");
`endif

        // reset asserted mid MEM_WRITE wait
        cyc(0, OP_SW, 0, 1, 4'd1, V_FETCH,    "rst-sw fetch");
        cyc(0, OP_SW, 0, 1, 4'd2, V_DECODE,   "rst-sw decode");
        cyc(0, OP_SW, 0, 1, 4'd3, V_MEM_ADDR, "rst-sw mem_addr");
        cyc(0, OP_SW, 0, 0, 4'd6, V_MEM_WR,   "rst-sw mem_write wait");
        #5;
        rst = 1'b1;
        #1;
        e.st   = 4'd0;
        e.vec  = V_ZERO;
        e.name = "async reset mid mem_write";
        compare(e);
        cyc(1, OP_SW, 0, 0, 4'd0, V_ZERO,  "rst-sw reset hold");
        cyc(0, OP_SW, 0, 1, 4'd0, V_ZERO,  "rst-sw idle after release");
        cyc(0, OP_R,  0, 1, 4'd1, V_FETCH, "rst-sw refetch");

        @(posedge clk);
        @(posedge clk);
        if (sb_q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL scoreboard drain: got %0d pending entries, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
